// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [PC_W-1:0]   RESET_PC = 32'h1c000000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h03400000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Redirect, instruction-SRAM and ID-handoff signals of the fetch controller.
interface if_fetch_ctrl_if;
  import fetch_pkg::*;

  logic              br_taken;
  logic [PC_W-1:0]   br_target;
  logic              ex_flush;
  logic [PC_W-1:0]   flush_target;
  logic              inst_sram_req;
  logic [PC_W-1:0]   inst_sram_addr;
  logic              inst_sram_addr_ok;
  logic              inst_sram_data_ok;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              from_allowin;
  logic              to_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_adef;

  modport master (
    input  br_taken, br_target, ex_flush, flush_target,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  from_allowin,
    output inst_sram_req, inst_sram_addr,
    output to_valid, if_pc, if_inst, if_adef
  );

  modport slave (
    output br_taken, br_target, ex_flush, flush_target,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output from_allowin,
    input  inst_sram_req, inst_sram_addr,
    input  to_valid, if_pc, if_inst, if_adef
  );

endinterface

// File: rtl/if_inst_buf.sv
// One-entry holding register for the fetched instruction presented to ID.
module if_inst_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_adef,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic              o_adef
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;
  logic              r_adef;

  // pc/inst are left as-is on pop or flush; only valid qualifies them
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_adef  <= 1'b0;
    end else if (i_flush || i_pop) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_adef  <= i_adef;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_adef  = r_adef;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns fetch PC, one outstanding SRAM request, redirect cancel.
// Optional alignment fault generation when IF_ADEF_CHECK_EN is defined.
//
// state | meaning
// REQ   | request driven at fetch_pc, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok (dropped if cancel set)
// HOLD  | buffer valid toward ID, waiting for allowin or redirect
module if_fetch_ctrl
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  if_fetch_ctrl_if.master bus
);

  fetch_state_e      r_state, w_state_nxt;
  logic [PC_W-1:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic              r_cancel, w_cancel_nxt;

  logic              w_redirect;
  logic [PC_W-1:0]   w_target;
  logic              w_misalign;
  logic              w_req;
  logic              w_buf_load;
  logic              w_buf_pop;
  logic              w_buf_flush;
  logic              w_buf_adef;
  logic [INST_W-1:0] w_buf_inst;
  logic              w_buf_valid;
  logic [PC_W-1:0]   w_buf_pc;
  logic [INST_W-1:0] w_buf_inst_q;
  logic              w_buf_adef_q;

  assign w_redirect = bus.ex_flush | bus.br_taken;
  assign w_target   = bus.ex_flush ? bus.flush_target : bus.br_target;

`ifdef IF_ADEF_CHECK_EN
  assign w_misalign = (r_fetch_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= REQ;
      r_fetch_pc <= RESET_PC;
      r_cancel   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_cancel   <= w_cancel_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_cancel_nxt   = r_cancel;
    w_req          = 1'b0;
    w_buf_load     = 1'b0;
    w_buf_pop      = 1'b0;
    w_buf_flush    = 1'b0;
    w_buf_adef     = 1'b0;
    w_buf_inst     = bus.inst_sram_rdata;

    unique case (r_state)
      REQ: begin
        if (w_misalign) begin
          if (w_redirect) begin
            w_fetch_pc_nxt = w_target;
          end else begin
            w_buf_load  = 1'b1;
            w_buf_adef  = 1'b1;
            w_buf_inst  = '0;
            w_state_nxt = HOLD;
          end
        end else begin
          w_req = 1'b1;
          if (w_redirect) begin
            w_fetch_pc_nxt = w_target;
          end
          // once accepted, a redirect can only mark the response as stale
          if (bus.inst_sram_addr_ok) begin
            w_state_nxt  = WAIT;
            w_cancel_nxt = w_redirect;
          end
        end
      end

      WAIT: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = w_target;
        end
        if (bus.inst_sram_data_ok) begin
          w_cancel_nxt = 1'b0;
          if (r_cancel || w_redirect) begin
            w_state_nxt = REQ;
          end else begin
            w_buf_load  = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (w_redirect) begin
          w_cancel_nxt = 1'b1;
        end
      end

      HOLD: begin
        if (w_redirect) begin
          w_buf_flush    = 1'b1;
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = REQ;
        end else if (bus.from_allowin) begin
          w_buf_pop      = 1'b1;
          w_fetch_pc_nxt = pc_next(r_fetch_pc);
          w_state_nxt    = REQ;
        end
      end

      default: begin
        w_state_nxt = REQ;
      end
    endcase
  end

  assign bus.inst_sram_req  = w_req & ~reset;
  assign bus.inst_sram_addr = r_fetch_pc;

  if_inst_buf u_inst_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_pop   (w_buf_pop),
    .i_flush (w_buf_flush),
    .i_pc    (r_fetch_pc),
    .i_inst  (w_buf_inst),
    .i_adef  (w_buf_adef),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_inst  (w_buf_inst_q),
    .o_adef  (w_buf_adef_q)
  );

  assign bus.to_valid = w_buf_valid;
  assign bus.if_pc    = w_buf_pc;
  assign bus.if_inst  = w_buf_inst_q;
`ifdef IF_ADEF_CHECK_EN
  assign bus.if_adef  = w_buf_adef_q;
`else
  assign bus.if_adef  = 1'b0;
  logic w_unused_adef;
  assign w_unused_adef = w_buf_adef_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a scoreboard of instructions expected at ID handoff.
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  exp_t mon_e;

  if_fetch_ctrl_if bus ();

  if_fetch_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.br_taken          = 1'b0;
    bus.ex_flush          = 1'b0;
  endtask

  // Starts in a REQ cycle; returns at the start of the first HOLD cycle.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                          input int a_lat, input int d_lat, input bit push);
    for (int i = 0; i <= a_lat; i++) begin
      bus.inst_sram_addr_ok = (i == a_lat);
      #1;
      check("req", {31'd0, bus.inst_sram_req}, 32'd1);
      check("addr", bus.inst_sram_addr, addr);
      next_cyc();
    end
    for (int i = 1; i <= d_lat; i++) begin
      if (i == d_lat) begin
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = rdata;
        if (push) exp_q.push_back('{addr, rdata, 1'b0});
      end
      #1;
      check("req_wait", {31'd0, bus.inst_sram_req}, 32'd0);
      next_cyc();
    end
  endtask

  task automatic expect_hold(input logic [31:0] pc, input logic [31:0] inst);
    #1;
    check("hold_valid", {31'd0, bus.to_valid}, 32'd1);
    check("hold_pc", bus.if_pc, pc);
    check("hold_inst", bus.if_inst, inst);
    check("hold_adef", {31'd0, bus.if_adef}, 32'd0);
    check("hold_req", {31'd0, bus.inst_sram_req}, 32'd0);
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset && bus.to_valid && bus.from_allowin) begin
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_pc", bus.if_pc, mon_e.pc);
        check("sb_inst", bus.if_inst, mon_e.inst);
        check("sb_adef", {31'd0, bus.if_adef}, {31'd0, mon_e.adef});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.br_taken          = 1'b0;
    bus.br_target         = '0;
    bus.ex_flush          = 1'b0;
    bus.flush_target      = '0;
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = '0;
    bus.from_allowin      = 1'b1;

    // reset values
    repeat (3) next_cyc();
    #1;
    check("rst_req", {31'd0, bus.inst_sram_req}, 32'd0);
    check("rst_valid", {31'd0, bus.to_valid}, 32'd0);
    check("rst_pc", bus.if_pc, 32'd0);
    check("rst_inst", bus.if_inst, 32'd0);
    check("rst_adef", {31'd0, bus.if_adef}, 32'd0);
    next_cyc();
    reset = 1'b0;

    // first fetch, addr_ok and data_ok one cycle late
    do_fetch(32'h1c000000, 32'h02800c21, 1, 2, 1'b1);
    expect_hold(32'h1c000000, 32'h02800c21);
    next_cyc();

    // ID stalls five cycles in HOLD
    bus.from_allowin = 1'b0;
    do_fetch(32'h1c000004, 32'h12345678, 0, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      expect_hold(32'h1c000004, 32'h12345678);
      next_cyc();
    end
    bus.from_allowin = 1'b1;
    expect_hold(32'h1c000004, 32'h12345678);
    next_cyc();

    // zero-wait back-to-back: one instruction every three cycles
    do_fetch(32'h1c000008, 32'h00000011, 0, 1, 1'b1);
    expect_hold(32'h1c000008, 32'h00000011);
    next_cyc();
    do_fetch(32'h1c00000c, 32'h00000022, 0, 1, 1'b1);
    expect_hold(32'h1c00000c, 32'h00000022);
    next_cyc();

    // branch in WAIT, stale data_ok three cycles later
    bus.inst_sram_addr_ok = 1'b1;
    #1;
    check("br_addr", bus.inst_sram_addr, 32'h1c000010);
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000100;
    #1;
    check("br_req0", {31'd0, bus.inst_sram_req}, 32'd0);
    next_cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("br_idle_req", {31'd0, bus.inst_sram_req}, 32'd0);
      check("br_idle_valid", {31'd0, bus.to_valid}, 32'd0);
      next_cyc();
    end
    bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata   = 32'hdeadbeef;
    next_cyc();
    check("br_stale_valid", {31'd0, bus.to_valid}, 32'd0);
    do_fetch(32'h1c000100, 32'h00000033, 0, 1, 1'b1);
    expect_hold(32'h1c000100, 32'h00000033);
    next_cyc();

    // ex_flush and br_taken together in HOLD: flush wins, buffer dropped
    bus.from_allowin = 1'b0;
    do_fetch(32'h1c000104, 32'h00000044, 0, 1, 1'b0);
    bus.ex_flush     = 1'b1;
    bus.flush_target = 32'h1c008000;
    bus.br_taken     = 1'b1;
    bus.br_target    = 32'h1c000200;
    #1;
    check("fl_valid_pre", {31'd0, bus.to_valid}, 32'd1);
    next_cyc();
    #1;
    check("fl_valid_post", {31'd0, bus.to_valid}, 32'd0);
    bus.from_allowin = 1'b1;

    // redirect with addr_ok, second redirect before data_ok
    bus.inst_sram_addr_ok = 1'b1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000020;
    #1;
    check("rr_addr", bus.inst_sram_addr, 32'h1c008000);
    check("rr_req", {31'd0, bus.inst_sram_req}, 32'd1);
    next_cyc();
    #1;
    check("rr_wait_req", {31'd0, bus.inst_sram_req}, 32'd0);
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000040;
    next_cyc();
    bus.inst_sram_data_ok = 1'b1;
    bus.inst_sram_rdata   = 32'hbadc0de0;
    next_cyc();
    check("rr_valid", {31'd0, bus.to_valid}, 32'd0);
    do_fetch(32'h1c000040, 32'h00000055, 0, 1, 1'b1);
    expect_hold(32'h1c000040, 32'h00000055);
    next_cyc();

    // redirect in REQ before addr_ok, then PC wrap at top of address space
    bus.br_taken  = 1'b1;
    bus.br_target = 32'hfffffffc;
    #1;
    check("wr_addr_old", bus.inst_sram_addr, 32'h1c000044);
    next_cyc();
    do_fetch(32'hfffffffc, 32'h00000066, 0, 2, 1'b1);
    expect_hold(32'hfffffffc, 32'h00000066);
    next_cyc();
    do_fetch(32'h00000000, 32'h00000077, 2, 1, 1'b1);
    expect_hold(32'h00000000, 32'h00000077);
    next_cyc();

    // misaligned target
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000102;
    #1;
    check("ma_addr_old", bus.inst_sram_addr, 32'h00000004);
    next_cyc();
`ifdef IF_ADEF_CHECK_EN
    #1;
    check("ma_noreq", {31'd0, bus.inst_sram_req}, 32'd0);
    exp_q.push_back('{32'h1c000102, 32'h0, 1'b1});
    next_cyc();
    #1;
    check("ma_valid", {31'd0, bus.to_valid}, 32'd1);
    check("ma_adef", {31'd0, bus.if_adef}, 32'd1);
    check("ma_pc", bus.if_pc, 32'h1c000102);
    check("ma_inst", bus.if_inst, 32'h0);
    next_cyc();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000200;
    #1;
    check("ma_noreq2", {31'd0, bus.inst_sram_req}, 32'd0);
    next_cyc();
    do_fetch(32'h1c000200, 32'h00000088, 0, 1, 1'b1);
    expect_hold(32'h1c000200, 32'h00000088);
    next_cyc();
`else
    do_fetch(32'h1c000102, 32'h00000088, 0, 1, 1'b1);
    expect_hold(32'h1c000102, 32'h00000088);
    next_cyc();
    #1;
    check("ma_next_addr", bus.inst_sram_addr, 32'h1c000106);
`endif

    next_cyc();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
